// File: rtl/act_pkg.sv
// Shared types and constants for the activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  localparam int SAT_CNT_W = 16;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

endpackage

// File: rtl/act_lane.sv
// One activation lane. The leaky product is formed from the raw input so the
// parent can register it in stage 1. Select and saturate work on the stage-1
// copy and feed stage 2.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALPHA_W = 8,
  parameter int FRAC_W  = 4,
  localparam int PROD_W = DATA_W + ALPHA_W + 1
) (
  input  logic signed [DATA_W-1:0]  x_i,
  input  logic        [ALPHA_W-1:0] alpha_i,
  output logic signed [PROD_W-1:0]  prod_o,
  input  logic signed [DATA_W-1:0]  s1_x_i,
  input  logic signed [PROD_W-1:0]  s1_prod_i,
  input  act_mode_e                 mode_i,
  input  logic signed [DATA_W-1:0]  clip_i,
  output logic        [DATA_W-1:0]  y_o,
  output logic                      sat_o
);

  localparam logic signed [PROD_W-1:0] MAX_V =
    {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MIN_V =
    {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] wide;
  logic signed [DATA_W-1:0] clip_pos;

  // Signed input times zero-extended alpha, full precision.
  always_comb begin
    x_ext  = PROD_W'(x_i);
    a_ext  = PROD_W'({1'b0, alpha_i});
    prod_o = x_ext * a_ext;
  end

  // Mode select in wide precision, then clamp to the signed output range.
  always_comb begin
    clip_pos = clip_i[DATA_W-1] ? '0 : clip_i;
    wide     = PROD_W'(s1_x_i);
    case (mode_i)
      ACT_BYPASS: wide = PROD_W'(s1_x_i);
      ACT_RELU:   if (s1_x_i[DATA_W-1]) wide = '0;
      ACT_LEAKY:  if (s1_x_i[DATA_W-1]) wide = s1_prod_i >>> FRAC_W;
      ACT_CLIP: begin
        if (s1_x_i[DATA_W-1])     wide = '0;
        else if (s1_x_i > clip_pos) wide = PROD_W'(clip_pos);
      end
      default:    wide = PROD_W'(s1_x_i);
    endcase

    sat_o = 1'b0;
    y_o   = wide[DATA_W-1:0];
    if (wide > MAX_V) begin
      y_o   = MAX_V[DATA_W-1:0];
      sat_o = 1'b1;
    end else if (wide < MIN_V) begin
      y_o   = MIN_V[DATA_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage elementwise activation over LANES signed lanes with a
// valid/ready stream on both sides and a sticky saturation counter.
module activation_pipe
  import act_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int ALPHA_W = 8,
  parameter int FRAC_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cfg_mode,
  input  logic [ALPHA_W-1:0]      cfg_alpha,
  input  logic [DATA_W-1:0]       cfg_clip,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic                    m_last,
  input  logic                    sat_clr,
  output logic [SAT_CNT_W-1:0]    sat_count
);

  localparam int PROD_W = DATA_W + ALPHA_W + 1;

  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*DATA_W-1:0] s1_data_q;
  logic                    s1_last_q;
  act_mode_e               s1_mode_q;
  logic [DATA_W-1:0]       s1_clip_q;
  logic signed [PROD_W-1:0] s1_prod_q [LANES];

  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*DATA_W-1:0] s2_data_q;
  logic                    s2_last_q;

  logic [SAT_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;
  logic [SAT_CNT_W-1:0]    sat_inc;
  logic [SAT_CNT_W:0]      sat_sum;

  logic                    s1_load, s2_load;
  logic signed [PROD_W-1:0] lane_prod [LANES];
  logic [LANES*DATA_W-1:0] lane_y;
  logic [LANES-1:0]        lane_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_W (DATA_W),
      .ALPHA_W(ALPHA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x_i      (s_data[g*DATA_W +: DATA_W]),
      .alpha_i  (cfg_alpha),
      .prod_o   (lane_prod[g]),
      .s1_x_i   (s1_data_q[g*DATA_W +: DATA_W]),
      .s1_prod_i(s1_prod_q[g]),
      .mode_i   (s1_mode_q),
      .clip_i   (s1_clip_q),
      .y_o      (lane_y[g*DATA_W +: DATA_W]),
      .sat_o    (lane_sat[g])
    );
  end

  // Stage 2 takes S1 when it is empty or being drained; S1 then frees up.
  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || m_ready);
    s_ready    = !s1_valid_q || s2_load;
    s1_load    = s_valid && s_ready;
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !m_ready);
  end

  // Saturating count of lanes clamped as beats enter S2; clear wins.
  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_inc = sat_inc + SAT_CNT_W'(lane_sat[i]);
    end
    sat_sum   = {1'b0, sat_cnt_q} + {1'b0, sat_inc};
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)      sat_cnt_d = '0;
    else if (s2_load) sat_cnt_d = sat_sum[SAT_CNT_W] ? SAT_CNT_MAX : sat_sum[SAT_CNT_W-1:0];
  end

  // Stage 1: raw beat, accept-time config and lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= ACT_BYPASS;
      s1_clip_q  <= '0;
      for (int i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_data_q <= s_data;
        s1_last_q <= s_last;
        s1_mode_q <= act_mode_e'(cfg_mode);
        s1_clip_q <= cfg_clip;
        for (int i = 0; i < LANES; i++) s1_prod_q[i] <= lane_prod[i];
      end
    end
  end

  // Stage 2: activated result, held while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_data_q <= lane_y;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign m_valid   = s2_valid_q;
  assign m_data    = s2_data_q;
  assign m_last    = s2_last_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Scoreboard bench for activation_pipe: expected beats come from an integer
// model at accept time and are compared as the DUT emits them.
module tb_activation_pipe;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int AW = 8;
  localparam int FW = 4;
  localparam int BW = L * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] cfg_alpha;
  logic [DW-1:0] cfg_clip;
  logic          s_valid, s_ready;
  logic [BW-1:0] s_data;
  logic          s_last;
  logic          m_valid, m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          sat_clr;
  logic [15:0]   sat_count;

  activation_pipe #(.DATA_W(DW), .LANES(L), .ALPHA_W(AW), .FRAC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_alpha(cfg_alpha),
    .cfg_clip(cfg_clip), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   exp_sat = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [BW-1:0] act_model(input logic [BW-1:0] d, input logic [1:0] mode,
                                                input logic [7:0] alpha, input logic [7:0] clip,
                                                output int nsat);
    logic [BW-1:0] r;
    logic [7:0]    b;
    int x, y, c, a;
    nsat = 0;
    r    = '0;
    a    = int'(alpha);
    for (int i = 0; i < L; i++) begin
      b = d[i*DW +: DW];
      x = $signed(b);
      c = $signed(clip);
      case (mode)
        2'd0: y = x;
        2'd1: y = (x < 0) ? 0 : x;
        2'd2: y = (x >= 0) ? x : ((x * a) >>> FW);
        default: begin
          if (c < 0) c = 0;
          y = (x < 0) ? 0 : ((x < c) ? x : c);
        end
      endcase
      if (y > 127) begin
        y = 127; nsat++;
      end else if (y < -128) begin
        y = -128; nsat++;
      end
      r[i*DW +: DW] = 8'(y);
    end
    return r;
  endfunction

  // Drive one beat, wait (bounded) for acceptance, then record the expectation.
  task automatic send_beat(input logic [BW-1:0] d, input logic last, input logic [1:0] mode,
                           input logic [7:0] alpha, input logic [7:0] clip);
    int   ns;
    int   w;
    exp_t e;
    s_valid = 1'b1; s_data = d; s_last = last;
    cfg_mode = mode; cfg_alpha = alpha; cfg_clip = clip;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      check_val("accept_timeout", w, 0);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.data = act_model(d, mode, alpha, clip, ns);
      e.last = last;
      sb_q.push_back(e);
      exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_val(tag, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output side: pop and compare on every transfer, and hold data steady under stall.
  logic          hold_v = 1'b0;
  logic [BW-1:0] hold_d;
  logic          hold_l;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_val("hold_valid", m_valid, 1);
        check_val("hold_data", m_data, hold_d);
        check_val("hold_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check_val("m_data", m_data, e.data);
          check_val("m_last", m_last, e.last);
          n_out++;
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [BW-1:0] SAT_BEAT = {4{8'h80}};

  initial begin
    int out0;
    rst_n = 1'b0; m_ready = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cfg_mode = 2'd0; cfg_alpha = '0; cfg_clip = '0; sat_clr = 1'b0;

    #23;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_m_last", m_last, 0);
    check_val("rst_sat_count", sat_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // Leaky with small alpha, plus two-cycle latency.
    send_beat(pk(-16, 37, 0, -1), 1'b0, 2'd2, 8'h02, 8'h00);
    @(negedge clk);
    check_val("lat_cycle1", m_valid, 0);
    @(negedge clk);
    check_val("lat_cycle2", m_valid, 1);
    wait_drain("drain_leaky");
    check_val("sat_leaky_small", sat_count, exp_sat);

    // Leaky saturating low.
    send_beat(pk(-100, 127, 0, 5), 1'b0, 2'd2, 8'h40, 8'h00);
    wait_drain("drain_leaky_sat");
    check_val("sat_leaky_big", sat_count, exp_sat);

    // Clip, negative clip, bypass, relu.
    send_beat(pk(120, -5, 96, 50), 1'b0, 2'd3, 8'h00, 8'h60);
    send_beat(pk(120, -5, 96, 50), 1'b0, 2'd3, 8'h00, 8'hF0);
    send_beat(pk(-128, 127, -1, 1), 1'b0, 2'd0, 8'h00, 8'h00);
    send_beat(pk(-128, 127, -1, 1), 1'b0, 2'd1, 8'h00, 8'h00);
    wait_drain("drain_modes");
    check_val("sat_modes", sat_count, exp_sat);

    // Mode changes on consecutive accepted beats.
    send_beat(pk(-20, -128, 10, -7), 1'b0, 2'd1, 8'h30, 8'h00);
    send_beat(pk(-20, -128, 10, -7), 1'b0, 2'd2, 8'h30, 8'h00);
    send_beat(pk(-20, -128, 10, -7), 1'b0, 2'd3, 8'h30, 8'h05);
    wait_drain("drain_switch");
    check_val("sat_switch", sat_count, exp_sat);

    // Ten-beat frame with a five-cycle sink stall.
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_beat(BW'($urandom), (i == 9), 2'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("stall_s_ready", s_ready, 0);
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain("drain_stream");
    check_val("stream_count", n_out - out0, 10);
    check_val("sat_stream", sat_count, exp_sat);

    // Drive the counter into its ceiling and past it.
    begin
      int guard;
      guard = 0;
      while (exp_sat < 65535 && guard < 20000) begin
        send_beat(SAT_BEAT, 1'b0, 2'd2, 8'hFF, 8'h00);
        guard++;
      end
    end
    repeat (4) send_beat(SAT_BEAT, 1'b0, 2'd2, 8'hFF, 8'h00);
    wait_drain("drain_sat_fill");
    check_val("sat_sticky", sat_count, 16'hFFFF);

    // Clear in the same cycle a saturated beat enters stage 2.
    send_beat(SAT_BEAT, 1'b0, 2'd2, 8'hFF, 8'h00);
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    exp_sat = 0;
    wait_drain("drain_clr");
    check_val("sat_clr_wins", sat_count, exp_sat);
    send_beat(pk(-100, 0, 0, 0), 1'b0, 2'd2, 8'h40, 8'h00);
    wait_drain("drain_after_clr");
    check_val("sat_after_clr", sat_count, exp_sat);

    // Asynchronous reset with beats in flight.
    send_beat(pk(1, 2, 3, 4), 1'b0, 2'd0, 8'h00, 8'h00);
    send_beat(pk(-100, 5, 6, 7), 1'b0, 2'd2, 8'h40, 8'h00);
    send_beat(pk(9, 10, 11, 12), 1'b1, 2'd0, 8'h00, 8'h00);
    #1;
    check_val("pre_rst_valid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_async_valid", m_valid, 0);
    check_val("rst_async_sat", sat_count, 0);
    sb_q.delete();
    exp_sat = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_stale", m_valid, 0);
    end
    @(posedge clk); #1;
    send_beat(pk(-16, 37, 0, -1), 1'b1, 2'd2, 8'h02, 8'h00);
    @(negedge clk);
    check_val("post_rst_lat1", m_valid, 0);
    @(negedge clk);
    check_val("post_rst_lat2", m_valid, 1);
    wait_drain("drain_post_rst");
    check_val("post_rst_sat", sat_count, exp_sat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed two's-complement element width.
REQ-002 SHALL have parameter LANES, default 4, elements per beat.
REQ-003 SHALL have parameter ALPHA_W, default 8, unsigned alpha width.
REQ-004 SHALL have parameter FRAC_W, default 4, fractional bits of alpha (alpha = cfg_alpha / 2^FRAC_W).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cfg_mode  in  2  0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
REQ-009 cfg_alpha  in  ALPHA_W  leaky slope, unsigned fixed point.
REQ-010 cfg_clip  in  DATA_W  clipped-ReLU ceiling, signed, treated as 0 if negative.
REQ-011 s_valid / s_ready  in / out  1 / 1  input handshake.
REQ-012 s_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-013 s_last  in  1  end-of-frame marker, passed through aligned with data.
REQ-014 m_valid / m_ready  out / in  1 / 1  output handshake.
REQ-015 m_data  out  LANES*DATA_W  activated lanes, same packing as s_data.
REQ-016 m_last  out  1  delayed s_last.
REQ-017 sat_clr  in  1  synchronous clear of sat_count.
REQ-018 sat_count  out  16  number of lane results saturated since reset or clear.

Function
REQ-019 A beat SHALL transfer on s_valid&&s_ready (input) and m_valid&&m_ready (output).
REQ-020 Pipeline SHALL have 2 register stages: S1 captures data, last, and the cfg_* sampled on input acceptance, plus lane products; S2 holds the selected, saturated result.
REQ-021 Latency SHALL be 2 cycles from input transfer to m_valid with m_ready held high; throughput 1 beat/cycle.
REQ-022 Each stage SHALL load when empty or when its content moves downstream in the same cycle; s_ready = !S1_valid || S1 advancing.
REQ-023 While m_valid&&!m_ready, m_data and m_last SHALL remain stable; no beat SHALL be dropped, duplicated or reordered.
REQ-024 Mode 0: y = x. Mode 1: y = x<0 ? 0 : x.
REQ-025 Mode 2: y = x for x>=0; else y = (x*cfg_alpha) arithmetic-shifted right by FRAC_W (floor), product width DATA_W+ALPHA_W+1.
REQ-026 Mode 3: y = x<0 ? 0 : min(x, max(cfg_clip,0)).
REQ-027 Results outside the signed DATA_W range SHALL saturate to -2^(DATA_W-1) or 2^(DATA_W-1)-1 and count as saturated.
REQ-028 Config changes SHALL affect only beats accepted after the change; in-flight beats keep their sampled config.
REQ-029 sat_count SHALL add the number of saturated lanes of each beat when it enters S2, sticking at 0xFFFF.
REQ-030 sat_clr SHALL take precedence: count becomes 0 that cycle and the increment of that cycle is discarded.

Reset
REQ-031 On rst_n low, S1/S2 valid, m_valid, m_last, m_data and sat_count SHALL go to 0 immediately; s_ready SHALL read 1 after release.
REQ-032 Reset mid-stream SHALL discard all in-flight beats; the first beat after release behaves as after power-up.

Structure
REQ-033 Package act_pkg SHALL hold the mode enumeration (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP) and the sat_count width constant.
REQ-034 Per-lane arithmetic (product, select, saturate, sat flag) SHALL be sub-module act_lane, instantiated LANES times; handshake and counter stay in activation_pipe.

Verification (defaults DATA_W=8, FRAC_W=4, LANES=4)
REQ-035 Mode 2, alpha 0x02, lanes {-16, 37, 0, -1} -> {-2, 37, 0, -1} exactly 2 cycles later, sat_count 0.
REQ-036 Mode 2, alpha 0x40, lane -100 -> -128 (0x80), sat_count increments by 1; lane 127 unchanged.
REQ-037 Mode 3, clip 0x60, lanes {120, -5, 96, 50} -> {96, 0, 96, 50}; clip 0xF0 -> all lanes 0 or negative-clamped to 0.
REQ-038 10-beat stream with s_last on beat 10, m_ready low cycles 3-7 -> s_ready low after 2 held beats, m_data stable, all 10 beats in order, m_last only on beat 10.
REQ-039 Mode switched 1->2 on consecutive accepted beats -> each beat uses its own accept-time mode.
REQ-040 sat_count preloaded to 0xFFFF by saturating traffic stays 0xFFFF; sat_clr concurrent with saturated beat -> 0; rst_n pulse mid-stream -> m_valid 0 asynchronously, no stale beat after release.
